// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial unsigned subtractor, LSB-first through one 1-bit cell
module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res_next;
  logic [CW-1:0] r_cnt;
  logic r_br, w_d, w_br_next, w_last;
  // two cascaded half-subtractors: a-b, then minus the running borrow
  assign w_d = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = WIDTH'({w_d, r_res} >> 1);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy = r_state == RUN;
    done = r_state == DONE;
    if (r_state == IDLE) w_next = start ? RUN : IDLE;
    else if (r_state == RUN) w_next = w_last ? DONE : RUN;
    else w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_br <= 1'b0;
      r_cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a <= a;
      r_b <= b;
      r_br <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_res <= w_res_next;
      r_br <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        diff <= w_res_next;
        borrow_out <= w_br_next;
      end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: directed and reference-checked tests at WIDTH 1, 8 and 16
module tb_serial_subtract_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, st = 1'b0;
  logic [31:0] ai = '0, bi = '0;
  int sel = 8;
  int n_chk = 0, n_fail = 0;
  logic [31:0] pd [3];
  logic busy1, done1, bo1, busy8, done8, bo8, busy16, done16, bo16;
  logic [0:0] d1;
  logic [7:0] d8;
  logic [15:0] d16;
  logic m_busy, m_done, m_bo;
  logic [31:0] m_diff;

  always #5 clk = ~clk;

  serial_subtract_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st && sel == 1),
    .a(ai[0:0]), .b(bi[0:0]), .busy(busy1), .done(done1), .diff(d1), .borrow_out(bo1));
  serial_subtract_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st && sel == 8),
    .a(ai[7:0]), .b(bi[7:0]), .busy(busy8), .done(done8), .diff(d8), .borrow_out(bo8));
  serial_subtract_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(st && sel == 16),
    .a(ai[15:0]), .b(bi[15:0]), .busy(busy16), .done(done16), .diff(d16), .borrow_out(bo16));

  assign m_busy = sel == 1 ? busy1 : sel == 16 ? busy16 : busy8;
  assign m_done = sel == 1 ? done1 : sel == 16 ? done16 : done8;
  assign m_bo   = sel == 1 ? bo1 : sel == 16 ? bo16 : bo8;
  assign m_diff = sel == 1 ? 32'(d1) : sel == 16 ? 32'(d16) : 32'(d8);

  function automatic int ix();
    return sel == 1 ? 0 : sel == 8 ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic op(input logic [31:0] av, input logic [31:0] bv);
    logic [32:0] one;
    logic [31:0] mask, exp_d;
    logic exp_b;
    int cyc, nb;
    one = 33'd1 << sel;
    mask = one[31:0] - 32'd1;
    exp_d = (av - bv) & mask;
    exp_b = (av & mask) < (bv & mask);
    @(negedge clk);
    st = 1'b1; ai = av; bi = bv;
    @(negedge clk);
    st = 1'b0; ai = $urandom; bi = $urandom;
    cyc = 0; nb = 0;
    while (!m_done && cyc < 40) begin
      if (m_busy) nb++;
      if (cyc == 0 || cyc == sel - 1) chk("hold", m_diff, pd[ix()]);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, sel);
    chk("busy_cycles", nb, sel);
    chk("diff", m_diff, exp_d);
    chk("borrow_out", 32'(m_bo), 32'(exp_b));
    chk("overlap", 32'(m_busy), 0);
    pd[ix()] = exp_d;
    @(negedge clk);
    chk("done_width", 32'(m_done), 0);
  endtask

  initial begin
    int first, second, ovl, nd;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;
    #12;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", m_diff, 0);
    chk("rst_bo", 32'(bo8), 0);
    rst_n = 1'b1;
    sel = 8;
    op(200, 55);
    op(5, 10);
    op(0, 1);
    op(255, 255);
    // start held high while operands churn; only E0 values count
    @(negedge clk);
    st = 1'b1; ai = 100; bi = 1;
    first = -1; second = -1; ovl = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (m_busy && m_done) ovl++;
      if (m_done) begin
        if (first < 0) begin
          first = i;
          chk("cont_diff", m_diff, 99);
          chk("cont_bo", 32'(m_bo), 0);
        end else if (second < 0) begin
          second = i;
          chk("cont_diff2", m_diff, 40);
        end
      end
      if (i == 15) chk("cont_hold", m_diff, 99);
      ai = 32'(i * 7); bi = 32'(i * 3);
    end
    st = 1'b0;
    chk("cont_first", 32'(first), 9);
    chk("cont_period", 32'(second - first), 10);
    chk("cont_overlap", 32'(ovl), 0);
    repeat (12) @(negedge clk);
    chk("cont_diff3", m_diff, 80);
    pd[1] = 80;
    op(5, 10);
    @(negedge clk);
    st = 1'b1; ai = 7; bi = 2;
    @(negedge clk);
    st = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_done", 32'(done8), 0);
    chk("arst_diff", m_diff, 0);
    chk("arst_bo", 32'(bo8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("no_done_after_abort", 32'(nd), 0);
    op(9, 3);
    sel = 1;
    op(0, 0);
    op(1, 0);
    op(0, 1);
    op(1, 1);
    sel = 8;
    for (int i = 0; i < 1000; i++) op($urandom, $urandom);
    sel = 16;
    for (int i = 0; i < 1000; i++) op($urandom, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
- Bit-serial WIDTH-bit unsigned subtractor controller: one shared 1-bit subtract cell, built from two cascaded half-subtractor stages (a−b, then −borrow).
- Sequences operands through the cell LSB-first, one bit per clock; holds the running borrow in a flop.
- Collects the difference in a shift register; start/busy/done handshake to the surrounding datapath.
- Trades latency for area versus a parallel subtractor.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  single rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  (a − b) mod 2^WIDTH; held until the next completion
borrow_out  output  1  final borrow; 1 iff a < b (unsigned); held with diff

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal operand shift regs, borrow flop and bit counter cleared. Reset mid-RUN aborts the operation; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE: on edge E0 with start=1:
  - Load a, b into shift regs.
  - Clear borrow flop and counter (cnt=0).
  - Go to RUN.
  - start=0 stays in IDLE.
- RUN: at each edge, the cell computes:
  - d = a[0] ^ b[0] ^ br
  - br_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br)
  - Shift a and b right by 1.
  - Shift d into the MSB of the result shift reg.
  - br <= br_next; cnt <= cnt+1.
- Leaving RUN: at the edge where cnt==WIDTH−1 (edge E_WIDTH):
  - diff <= final result register contents.
  - borrow_out <= br_next.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally on the next edge.
- Latency: start accepted at E0 → done high in the cycle after E_WIDTH (WIDTH+1 cycles start-to-done). Next start may be accepted at the edge leaving DONE+1, i.e. throughput one op per WIDTH+2 cycles.
- busy=1 exactly in RUN (WIDTH cycles); done=1 exactly in DONE; never both high.
- start while in RUN or DONE: ignored, not queued. a/b changes after E0 have no effect.
- diff and borrow_out change only at the RUN→DONE edge or reset; stable otherwise, including during the next RUN.
- Counter width: clog2(WIDTH)+1 bits, no wrap within an operation. WIDTH=1 gives a single RUN cycle.
- Arithmetic: unsigned only. Result equals the WIDTH-bit truncation of a−b, with borrow_out the 2^WIDTH borrow.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then WIDTH=8, a=200, b=55, start one cycle → busy high 8 cycles; done pulse in cycle 9 after start edge; diff=145, borrow_out=0.
- a=5, b=10 → diff=251 (0xFB), borrow_out=1. Then a=0, b=1 → diff=255, borrow_out=1. Then a=255, b=255 → diff=0, borrow_out=0. Each done is exactly one cycle wide.
- start held high continuously with a=100, b=1, changing a/b every cycle during RUN → only the E0-sampled operands used (diff=99, borrow_out=0). Next op accepted only after return to IDLE, giving a WIDTH+2 cycle period. busy and done never overlap.
- Assert rst_n low mid-RUN (after 4 bits) → busy, done, diff, borrow_out go 0 immediately (asynchronously). No done follows. A fresh op a=9, b=3 afterwards gives diff=6.
- Parameter WIDTH=1: all four (a,b) pairs → (0,0)→0/0, (1,0)→1/0, (0,1)→1/1, (1,1)→0/0. done in 2nd cycle after start.
- Random: 1000 ops at WIDTH=8 and WIDTH=16 compared against a reference (a−b) mod 2^WIDTH and (a<b); diff/borrow_out verified stable between completions.
